// File: rtl/rx_fifo_param.sv
// Receive FIFO for the serial receive path: first-word-fall-through buffering of
// frame-done strobes with occupancy, threshold, sticky error and character-timeout status.
module rx_fifo_param #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned THRESH = 24,
  parameter int unsigned TO_CYC = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       fifo_en_i,
  input  logic                       rx_en_i,
  input  logic                       wr_stb_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_stb_i,
  input  logic                       flush_i,
  input  logic                       err_clr_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       data_avail_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       thresh_o,
  output logic                       timeout_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TO_CYC + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [TW-1:0]     to_cnt;
  logic              overflow;
  logic              underflow;

  logic push_req;
  logic pop_req;
  logic is_empty;
  logic is_full;
  logic pop_ok;
  logic push_ok;
  logic set_ovf;
  logic set_udf;
  logic mem_we;

  // Acceptance decode; flush overrides both ports and suppresses their errors.
  always_comb begin
    push_req = fifo_en_i & rx_en_i & wr_stb_i;
    pop_req  = fifo_en_i & rd_stb_i;
    is_empty = (level == '0);
    is_full  = (level == LW'(DEPTH));
    pop_ok   = pop_req & ~is_empty;
    push_ok  = push_req & (~is_full | pop_ok);
    set_ovf  = push_req & ~push_ok & ~flush_i;
    set_udf  = pop_req & is_empty & ~flush_i;
    mem_we   = push_ok & ~flush_i & ~rst_i;
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_ptr] <= wr_data_i;
  end

  // Pointers, level, timeout counter and sticky errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      to_cnt    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop_ok)      level <= level + LW'(1);
        else if (pop_ok && !push_ok) level <= level - LW'(1);
      end

      if (flush_i || push_ok || pop_ok || is_empty) to_cnt <= '0;
      else if (to_cnt != TW'(TO_CYC))               to_cnt <= to_cnt + TW'(1);

      if (set_ovf)        overflow <= 1'b1;
      else if (err_clr_i) overflow <= 1'b0;

      if (set_udf)        underflow <= 1'b1;
      else if (err_clr_i) underflow <= 1'b0;
    end
  end

  // Status decoded from registered state only.
  always_comb begin
    rd_data_o    = is_empty ? '0 : mem[rd_ptr];
    empty_o      = is_empty;
    data_avail_o = ~is_empty;
    full_o       = is_full;
    level_o      = level;
    thresh_o     = (level >= LW'(THRESH));
    timeout_o    = (to_cnt == TW'(TO_CYC));
    overflow_o   = overflow;
    underflow_o  = underflow;
    wr_ptr_o     = wr_ptr;
    rd_ptr_o     = rd_ptr;
  end

endmodule

// File: tb/tb_rx_fifo_param.sv
// Directed bench for rx_fifo_param: vector table for basic push/pop, then
// hand-written sequences for full, wrap, timeout, flush and reset corners.
module tb_rx_fifo_param;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fifo_en = 1'b0;
  logic              rx_en = 1'b0;
  logic              wr_stb = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_stb = 1'b0;
  logic              flush = 1'b0;
  logic              err_clr = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              data_avail;
  logic              empty;
  logic              full;
  logic [5:0]        level;
  logic              thresh;
  logic              timeout;
  logic              overflow;
  logic              underflow;
  logic [4:0]        wr_ptr;
  logic [4:0]        rd_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  rx_fifo_param #(.DATA_W(12), .DEPTH(32), .THRESH(24), .TO_CYC(64)) dut (
    .clk_i(clk), .rst_i(rst), .fifo_en_i(fifo_en), .rx_en_i(rx_en),
    .wr_stb_i(wr_stb), .wr_data_i(wr_data), .rd_stb_i(rd_stb),
    .flush_i(flush), .err_clr_i(err_clr), .rd_data_o(rd_data),
    .data_avail_o(data_avail), .empty_o(empty), .full_o(full),
    .level_o(level), .thresh_o(thresh), .timeout_o(timeout),
    .overflow_o(overflow), .underflow_o(underflow),
    .wr_ptr_o(wr_ptr), .rd_ptr_o(rd_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, rx, wr;
    logic [11:0] data;
    logic        rd, fl, clr;
    int          lvl;
    logic [11:0] q;
    logic        emp, ful, thr, ovf, udf;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic rx, input logic wr,
                       input logic [11:0] d, input logic rd, input logic fl, input logic clr);
    rst = r; fifo_en = en; rx_en = rx; wr_stb = wr; wr_data = d;
    rd_stb = rd; flush = fl; err_clr = clr;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [11:0] d);
    drive(1'b0, 1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    // Table: reset, push 0x100..0x107, pop 8, pop-on-empty with push, clear, pop.
    tbl[0] = '{1,1,1,0,12'h000,0,0,0, 0,12'h000,1,0,0,0,0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{0,1,1,1,12'(32'h100 + i - 1),0,0,0, i,12'h100,0,0,0,0,0};
    for (int i = 9; i <= 16; i++) begin
      k = i - 8;
      tbl[i] = '{0,1,1,0,12'h000,1,0,0, 8 - k,
                 (k < 8) ? 12'(32'h100 + k) : 12'h000, (k == 8), 0,0,0,0};
    end
    tbl[17] = '{0,1,1,1,12'h055,1,0,0, 1,12'h055,0,0,0,0,1};
    tbl[18] = '{0,1,1,0,12'h000,0,0,1, 1,12'h055,0,0,0,0,0};
    tbl[19] = '{0,1,1,0,12'h000,1,0,0, 0,12'h000,1,0,0,0,0};

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].rx, tbl[i].wr, tbl[i].data,
            tbl[i].rd, tbl[i].fl, tbl[i].clr);
      chk($sformatf("vec%0d level", i), int'(level), tbl[i].lvl);
      chk($sformatf("vec%0d rd_data", i), int'(rd_data), int'(tbl[i].q));
      chk($sformatf("vec%0d empty", i), int'(empty), int'(tbl[i].emp));
      chk($sformatf("vec%0d avail", i), int'(data_avail), int'(!tbl[i].emp));
      chk($sformatf("vec%0d full", i), int'(full), int'(tbl[i].ful));
      chk($sformatf("vec%0d thresh", i), int'(thresh), int'(tbl[i].thr));
      chk($sformatf("vec%0d overflow", i), int'(overflow), int'(tbl[i].ovf));
      chk($sformatf("vec%0d underflow", i), int'(underflow), int'(tbl[i].udf));
    end

    // Fill to full: threshold at 24, overflow on 33rd push, error clear.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      push(12'(32'h200 + i));
      if (i == 22) chk("thresh at 23", int'(thresh), 0);
      if (i == 23) chk("thresh at 24", int'(thresh), 1);
    end
    chk("full level", int'(level), 32);
    chk("full flag", int'(full), 1);
    chk("wr_ptr wrapped", int'(wr_ptr), 0);
    push(12'hFFF);
    chk("ovf set", int'(overflow), 1);
    chk("ovf level", int'(level), 32);
    chk("ovf head", int'(rd_data), 'h200);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    chk("ovf cleared", int'(overflow), 0);

    // Push+pop on full, then drain: 0xABC is last out, pointers wrapped.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12'hABC, 1'b1, 1'b0, 1'b0);
    chk("pp level", int'(level), 32);
    chk("pp full", int'(full), 1);
    chk("pp no ovf", int'(overflow), 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain %0d", i), int'(rd_data), (i < 31) ? ('h201 + i) : 'hABC);
      pop();
    end
    chk("drain empty", int'(empty), 1);
    chk("drain rd_ptr", int'(rd_ptr), 1);
    chk("drain wr_ptr", int'(wr_ptr), 1);

    // Character timeout: rises 64 edges after last push, cleared by a pop.
    do_reset();
    for (int i = 0; i < 3; i++) push(12'(32'h300 + i));
    for (int i = 0; i < 63; i++) idle();
    chk("to 63", int'(timeout), 0);
    idle();
    chk("to 64", int'(timeout), 1);
    pop();
    chk("to cleared", int'(timeout), 0);
    for (int i = 0; i < 63; i++) idle();
    chk("to2 63", int'(timeout), 0);
    idle();
    chk("to2 64", int'(timeout), 1);

    // Flush with same-cycle push keeps sticky errors and drops the push.
    do_reset();
    pop();
    chk("udf pre-flush", int'(underflow), 1);
    for (int i = 0; i < 10; i++) push(12'(32'h400 + i));
    chk("pre-flush level", int'(level), 10);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12'h111, 1'b0, 1'b1, 1'b0);
    chk("flush level", int'(level), 0);
    chk("flush wr_ptr", int'(wr_ptr), 0);
    chk("flush rd_ptr", int'(rd_ptr), 0);
    chk("flush rd_data", int'(rd_data), 0);
    chk("flush ovf", int'(overflow), 0);
    chk("flush udf kept", int'(underflow), 1);
    idle();
    chk("flush push dropped", int'(level), 0);

    // Flush on full with push must not raise overflow.
    for (int i = 0; i < 32; i++) push(12'(32'h500 + i));
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12'h111, 1'b0, 1'b1, 1'b0);
    chk("flush full ovf", int'(overflow), 0);
    chk("flush full level", int'(level), 0);

    // Reset with block disabled and a push pending.
    push(12'h600);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 12'h777, 1'b1, 1'b0, 1'b0);
    chk("rst level", int'(level), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst udf", int'(underflow), 0);
    chk("rst ptrs", int'({wr_ptr, rd_ptr}), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'h777, 1'b1, 1'b0, 1'b0);
    chk("dis level", int'(level), 0);
    chk("dis udf", int'(underflow), 0);
    chk("dis ovf", int'(overflow), 0);
    chk("dis timeout", int'(timeout), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
